polaris_divider: RTL and testbench

Iterative 64-bit integer divider for the Polaris execution stage, complementing the combinational `alu` adder. It computes quotient and remainder with one restoring-subtract step per clock, signed or unsigned. It uses a start/busy/done handshake, so the sequencer can stall while the ALU path stays single-cycle. Divide-by-zero and signed-overflow results follow RISC-V M-extension semantics.

---
 rtl/polaris_div_pkg.sv | 11 +
 rtl/polaris_divider_if.sv | 26 ++
 rtl/polaris_div_step.sv | 22 ++
 rtl/polaris_divider.sv | 129 ++++++++++++
 tb/tb_polaris_divider.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/polaris_div_pkg.sv
// rtl/polaris_div_pkg.sv - shared constants for the Polaris iterative divider
package polaris_div_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int CNT_W        = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/polaris_divider_if.sv
// rtl/polaris_divider_if.sv - start/busy/done request and result bundle of the divider
interface polaris_divider_if
    import polaris_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            start_i;
    logic            signed_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] quotient_o;
    logic [XLEN-1:0] remainder_o;
    logic            dz_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, dz_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, dz_o
    );
endinterface

// File: rtl/polaris_div_step.sv
// rtl/polaris_div_step.sv - one combinational restoring-division step
module polaris_div_step
    import polaris_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_msb,
    input  logic [XLEN-1:0] i_dvsr,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_trial;

    // i_rem < i_dvsr always holds, so the XLEN+1-bit difference never overflows its sign bit
    assign w_shift = {i_rem, i_msb};
    assign w_trial = w_shift - {1'b0, i_dvsr};
    assign o_qbit  = ~w_trial[XLEN];
    assign o_rem   = o_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/polaris_divider.sv
// rtl/polaris_divider.sv - iterative signed/unsigned divider, one restoring step per clock
module polaris_divider
    import polaris_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    polaris_divider_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_dvsr;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [XLEN-1:0]  r_quotient;
    logic [XLEN-1:0]  r_remainder;
    logic             r_dz_out;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_abs;
    logic [XLEN-1:0]  w_b_abs;
    logic             w_div0;
    logic             w_ovf;
    logic [XLEN-1:0]  w_step_rem;
    logic             w_qbit;

    assign w_a_neg = bus.signed_i & bus.dividend_i[XLEN-1];
    assign w_b_neg = bus.signed_i & bus.divisor_i[XLEN-1];
    assign w_a_abs = w_a_neg ? -bus.dividend_i : bus.dividend_i;
    assign w_b_abs = w_b_neg ? -bus.divisor_i  : bus.divisor_i;
    assign w_div0  = (bus.divisor_i == '0);
    assign w_ovf   = bus.signed_i && (bus.dividend_i == MIN_NEG) && (bus.divisor_i == '1);

    // r_quo doubles as the dividend shift register; quotient bits fill in from the bottom
    polaris_div_step #(.XLEN(XLEN)) u_step (
        .i_rem  (r_rem),
        .i_msb  (r_quo[XLEN-1]),
        .i_dvsr (r_dvsr),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dz        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz_out    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (w_div0) begin
                            r_quo   <= '1;
                            r_rem   <= bus.dividend_i;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                            r_dz    <= 1'b1;
                            r_state <= ST_FIX;
                        end else if (w_ovf) begin
                            r_quo   <= MIN_NEG;
                            r_rem   <= '0;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                            r_dz    <= 1'b0;
                            r_state <= ST_FIX;
                        end else begin
                            r_quo   <= w_a_abs;
                            r_rem   <= '0;
                            r_dvsr  <= w_b_abs;
                            r_q_neg <= w_a_neg ^ w_b_neg;
                            r_r_neg <= w_a_neg;
                            r_dz    <= 1'b0;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[XLEN-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_quotient  <= r_q_neg ? -r_quo : r_quo;
                    r_remainder <= r_r_neg ? -r_rem : r_rem;
                    r_dz_out    <= r_dz;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.quotient_o  = r_quotient;
    assign bus.remainder_o = r_remainder;
    assign bus.dz_o        = r_dz_out;

endmodule

// File: tb/tb_polaris_divider.sv
// tb/tb_polaris_divider.sv - self-checking bench for polaris_divider
module tb_polaris_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    polaris_divider_if #(.XLEN(64)) bus ();

    polaris_divider #(.XLEN(64)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        bit          sgn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        bit          dz;
        int          done_edge;
    } vec_t;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // RISC-V M-extension division, computed from plain arithmetic
    function automatic void model(input bit s, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output bit dz, output int done_edge);
        dz = 1'b0;
        done_edge = 65;
        if (b == 64'd0) begin
            q = ONES; r = a; dz = 1'b1; done_edge = 1;
        end else if (s && a == MINV && b == ONES) begin
            q = MINV; r = 64'd0; done_edge = 1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // drives a start, returns the edge index (start edge = 0) at which done was seen
    task automatic run_op(input bit s, input logic [63:0] a, input logic [63:0] b,
                          output int done_edge, output bit busy_ok);
        bus.signed_i   = s;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.start_i    = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        done_edge = 0;
        busy_ok = bus.busy_o;
        while (done_edge < 200) begin
            @(posedge clk); #1;
            done_edge++;
            if (bus.done_o) break;
            if (!bus.busy_o) busy_ok = 1'b0;
        end
    endtask

    task automatic apply(input vec_t v);
        int lat;
        bit bok;
        run_op(v.sgn, v.a, v.b, lat, bok);
        chk({v.name, ".done_edge"}, 64'(lat), 64'(v.done_edge));
        chk({v.name, ".quotient"}, bus.quotient_o, v.q);
        chk({v.name, ".remainder"}, bus.remainder_o, v.r);
        chk({v.name, ".dz"}, 64'(bus.dz_o), 64'(v.dz));
        chk({v.name, ".busy_during"}, 64'(bok), 64'd1);
        chk({v.name, ".busy_at_done"}, 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        chk({v.name, ".done_pulse"}, 64'(bus.done_o), 64'd0);
        chk({v.name, ".held_q"}, bus.quotient_o, v.q);
    endtask

    vec_t tbl[10];

    initial begin
        int lat;
        bit bok;
        vec_t v;
        bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.dividend_i = '0; bus.divisor_i = '0;

        tbl[0] = '{"u100_7",   1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65};
        tbl[1] = '{"s-7_2",    1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                   64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0, 65};
        tbl[2] = '{"s_ovf",    1'b1, MINV, ONES, MINV, 64'd0, 1'b0, 1};
        tbl[3] = '{"u_ovf",    1'b0, MINV, ONES, 64'd0, MINV, 1'b0, 65};
        tbl[4] = '{"s_dz",     1'b1, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1, 1};
        tbl[5] = '{"u_dz",     1'b0, 64'h1234, 64'd0, ONES, 64'h1234, 1'b1, 1};
        tbl[6] = '{"s7_-2",    1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                   64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 65};
        tbl[7] = '{"s-100_-7", 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
                   64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65};
        tbl[8] = '{"umax_1",   1'b0, ONES, 64'd1, ONES, 64'd0, 1'b0, 65};
        tbl[9] = '{"s-5_0",    1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,
                   ONES, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(bus.busy_o), 64'd0);
        chk("rst.done", 64'(bus.done_o), 64'd0);
        chk("rst.quotient", bus.quotient_o, 64'd0);
        chk("rst.remainder", bus.remainder_o, 64'd0);
        chk("rst.dz", 64'(bus.dz_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) apply(tbl[i]);

        for (int i = 0; i < 30; i++) begin
            int mode;
            mode = $urandom_range(0, 4);
            v.name = $sformatf("rnd%0d", i);
            v.sgn  = 1'($urandom_range(0, 1));
            v.a    = {$urandom, $urandom};
            case (mode)
                0: v.b = {$urandom, $urandom};
                1: v.b = 64'($urandom_range(0, 20));
                2: begin v.a = MINV; v.b = ONES; end
                3: v.b = {32'd0, $urandom} >> $urandom_range(0, 31);
                default: v.b = -64'($urandom_range(1, 1000));
            endcase
            model(v.sgn, v.a, v.b, v.q, v.r, v.dz, v.done_edge);
            apply(v);
        end

        // a start while busy must be ignored
        bus.signed_i = 1'b0; bus.dividend_i = 64'd100; bus.divisor_i = 64'd7;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = 0;
        while (lat < 200) begin
            if (lat == 19) begin
                bus.signed_i = 1'b1; bus.dividend_i = 64'd5; bus.divisor_i = 64'd0;
                bus.start_i = 1'b1;
            end
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            lat++;
            if (bus.done_o) break;
        end
        chk("ign.done_edge", 64'(lat), 64'd65);
        chk("ign.quotient", bus.quotient_o, 64'd14);
        chk("ign.remainder", bus.remainder_o, 64'd2);
        chk("ign.dz", 64'(bus.dz_o), 64'd0);

        // start in the done cycle is accepted
        run_op(1'b0, 64'd1000, 64'd10, lat, bok);
        chk("b2b.done_edge", 64'(lat), 64'd65);
        chk("b2b.quotient", bus.quotient_o, 64'd100);
        chk("b2b.remainder", bus.remainder_o, 64'd0);
        chk("b2b.busy_during", 64'(bok), 64'd1);
        @(posedge clk); #1;

        // reset in the middle of a run
        run_op(1'b0, 64'h1234, 64'd0, lat, bok);
        chk("pre.dz", 64'(bus.dz_o), 64'd1);
        bus.signed_i = 1'b0; bus.dividend_i = 64'd100; bus.divisor_i = 64'd7;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(bus.busy_o), 64'd0);
        chk("arst.done", 64'(bus.done_o), 64'd0);
        chk("arst.quotient", bus.quotient_o, 64'd0);
        chk("arst.remainder", bus.remainder_o, 64'd0);
        chk("arst.dz", 64'(bus.dz_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.idle", 64'(bus.busy_o), 64'd0);
        v = '{"post9_3", 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 65};
        apply(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
